// File: rtl/prod_accumulator_pkg.sv
// Shared defaults, accumulator width derivation and FSM encoding for the
// Booth-product frame accumulator.
package prod_accumulator_pkg;

  localparam int WIDTH_DEF = 128;
  localparam int GUARD_DEF = 8;
  localparam int CNTW_DEF  = 8;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/prod_accumulator_sat_acc_add.sv
// Extends a 2*WIDTH product to the accumulator width and adds it with
// saturation: signed clamp to max/min, unsigned clamp to all-ones.
module sat_acc_add
  import prod_accumulator_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  GUARD = GUARD_DEF,
  localparam int ACCW  = acc_width(WIDTH, GUARD)
) (
  input  logic [ACCW-1:0]    acc,
  input  logic [2*WIDTH-1:0] p,
  input  logic               Sign_out,
  output logic [ACCW-1:0]    sum,
  output logic               sat
);

  logic [ACCW-1:0] ext_s;
  logic [ACCW:0]   raw_s;

  // Extend, add with carry, then replace the raw sum when the mode overflows.
  always_comb begin
    if (Sign_out) begin
      ext_s = {{GUARD{p[2*WIDTH-1]}}, p};
    end else begin
      ext_s = {{GUARD{1'b0}}, p};
    end
    raw_s = {1'b0, acc} + {1'b0, ext_s};
    sum   = raw_s[ACCW-1:0];
    sat   = 1'b0;
    if (Sign_out) begin
      // Like-signed operands producing an opposite-signed result is overflow.
      if ((acc[ACCW-1] == ext_s[ACCW-1]) && (raw_s[ACCW-1] != acc[ACCW-1])) begin
        sat = 1'b1;
        if (ext_s[ACCW-1]) begin
          sum = {1'b1, {(ACCW-1){1'b0}}};
        end else begin
          sum = {1'b0, {(ACCW-1){1'b1}}};
        end
      end else begin
        sat = 1'b0;
      end
    end else if (raw_s[ACCW]) begin
      sat = 1'b1;
      sum = {ACCW{1'b1}};
    end else begin
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/prod_accumulator.sv
// Frame accumulator: sums len_cfg products into one saturating result and
// holds it until the downstream consumer takes it.
module prod_accumulator
  import prod_accumulator_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  GUARD = GUARD_DEF,
  parameter int  CNTW  = CNTW_DEF,
  localparam int ACCW  = acc_width(WIDTH, GUARD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] p,
  input  logic               Sign_out,
  input  logic               p_valid,
  output logic               p_ready,
  input  logic [CNTW-1:0]    len_cfg,
  input  logic               clear,
  output logic [ACCW-1:0]    acc_out,
  output logic               acc_valid,
  input  logic               acc_ready,
  output logic               ovf
);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [0:0]      state_r;
  logic [ACCW-1:0] acc_r;
  logic [CNTW-1:0] cnt_r;
  logic [CNTW-1:0] len_r;
  logic            ovf_r;

  logic            first_s;
  logic            take_s;
  logic            last_s;
  logic [CNTW-1:0] len_eff_s;
  logic [ACCW-1:0] acc_in_s;
  logic [ACCW-1:0] sum_s;
  logic            sat_s;

  // The first product of a frame takes its length straight from len_cfg.
  always_comb begin
    first_s = (cnt_r == {CNTW{1'b0}});
    if (!first_s) begin
      len_eff_s = len_r;
    end else if (len_cfg == {CNTW{1'b0}}) begin
      len_eff_s = CNT_ONE;
    end else begin
      len_eff_s = len_cfg;
    end
    p_ready   = (state_r == ST_ACC) && !rst;
    acc_valid = (state_r == ST_HOLD) && !rst;
    take_s    = p_valid && p_ready && !clear;
    last_s    = (cnt_r == (len_eff_s - CNT_ONE));
    acc_in_s  = first_s ? {ACCW{1'b0}} : acc_r;
  end

  sat_acc_add #(
    .WIDTH (WIDTH),
    .GUARD (GUARD)
  ) u_sat_acc_add (
    .acc      (acc_in_s),
    .p        (p),
    .Sign_out (Sign_out),
    .sum      (sum_s),
    .sat      (sat_s)
  );

  // Frame FSM, term counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACC;
      acc_r   <= {ACCW{1'b0}};
      cnt_r   <= {CNTW{1'b0}};
      len_r   <= CNT_ONE;
      ovf_r   <= 1'b0;
    end else if (clear) begin
      state_r <= ST_ACC;
      acc_r   <= {ACCW{1'b0}};
      cnt_r   <= {CNTW{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (take_s) begin
            acc_r <= sum_s;
            ovf_r <= ovf_r | sat_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (first_s) begin
              len_r <= len_eff_s;
            end
            if (last_s) begin
              state_r <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (acc_ready) begin
            state_r <= ST_ACC;
            acc_r   <= {ACCW{1'b0}};
            cnt_r   <= {CNTW{1'b0}};
            ovf_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_ACC;
        end
      endcase
    end
  end

  assign acc_out = acc_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench for prod_accumulator at WIDTH=4, GUARD=1 (9-bit accumulator)
// so saturation is reachable with directed and random products.
module tb_prod_accumulator;

  localparam int W  = 4;
  localparam int G  = 1;
  localparam int CW = 4;
  localparam int AW = 2 * W + G;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2*W-1:0] p = '0;
  logic          Sign_out = 1'b0;
  logic          p_valid = 1'b0;
  logic          p_ready;
  logic [CW-1:0] len_cfg = 4'd1;
  logic          clear = 1'b0;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready = 1'b0;
  logic          ovf;

  prod_accumulator #(.WIDTH(W), .GUARD(G), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .p(p), .Sign_out(Sign_out), .p_valid(p_valid),
    .p_ready(p_ready), .len_cfg(len_cfg), .clear(clear), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] acc;
    logic          ovf;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] last_acc;
  logic          last_ovf;

  // Frame-level reference: list of accepted terms reduced with clamped sums.
  bit     holding = 0;
  int     frame_n = 0;
  int     flen = 1;
  longint macc = 0;
  bit     movf = 0;

  always @(negedge clk) begin
    logic   exp_ready, exp_valid;
    longint v, a;
    exp_t   e;
    exp_ready = !holding && !rst;
    exp_valid = holding && !rst;
    total += 2;
    if (p_ready !== exp_ready) begin
      bad++;
      $display("FAIL p_ready actual=%b required=%b t=%0t", p_ready, exp_ready, $time);
    end
    if (acc_valid !== exp_valid) begin
      bad++;
      $display("FAIL acc_valid actual=%b required=%b t=%0t", acc_valid, exp_valid, $time);
    end
    if (rst || clear) begin
      holding = 0; frame_n = 0; macc = 0; movf = 0;
      exp_q.delete();
    end else if (holding) begin
      if (acc_ready) begin
        holding = 0; frame_n = 0; macc = 0; movf = 0;
      end
    end else if (p_valid) begin
      if (frame_n == 0) flen = (len_cfg == 0) ? 1 : int'(len_cfg);
      v = Sign_out ? longint'($signed(p)) : longint'(p);
      if (frame_n == 0) begin
        macc = (v + 512) % 512;
      end else if (Sign_out) begin
        a = (macc >= 256) ? macc - 512 : macc;
        a = a + v;
        if (a > 255) begin a = 255; movf = 1; end
        else if (a < -256) begin a = -256; movf = 1; end
        macc = (a + 512) % 512;
      end else begin
        a = macc + v;
        if (a > 511) begin a = 511; movf = 1; end
        macc = a;
      end
      frame_n++;
      if (frame_n == flen) begin
        e.acc = macc[AW-1:0];
        e.ovf = movf;
        exp_q.push_back(e);
        holding = 1;
      end
    end
  end

  // Monitor: every held cycle must show the queued result; pop on consume.
  always @(negedge clk) begin
    #1;
    if (acc_valid === 1'b1 && !rst && !clear) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result actual=%h required=none t=%0t", acc_out, $time);
      end else if (acc_out !== exp_q[0].acc || ovf !== exp_q[0].ovf) begin
        bad++;
        $display("FAIL result actual=%h/%b required=%h/%b t=%0t",
                 acc_out, ovf, exp_q[0].acc, exp_q[0].ovf, $time);
      end
      if (acc_ready && exp_q.size() != 0) begin
        last_acc = acc_out;
        last_ovf = ovf;
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] pv, input logic s);
    bit ok = 0;
    p_valid = 1'b1; p = pv; Sign_out = s;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = p_ready;
      tick();
    end
    p_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = acc_valid;
    end
    tick();
    if (!seen) chk("drain_timeout", 0, 1);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    len_cfg = 4'd3;
    send(8'd5, 1'b0); send(8'd7, 1'b0); send(8'd9, 1'b0);
    drain();
    chk("unsigned_sum", last_acc, 21);
    chk("unsigned_ovf", last_ovf, 0);

    len_cfg = 4'd2;
    send(8'hFD, 1'b1); send(8'h01, 1'b1);
    drain();
    chk("signed_sum", last_acc, 9'h1FE);
    chk("signed_ovf", last_ovf, 0);

    len_cfg = 4'd3;
    repeat (3) send(8'hFF, 1'b0);
    drain();
    chk("usat_sum", last_acc, 511);
    chk("usat_ovf", last_ovf, 1);
    repeat (3) send(8'h80, 1'b1);
    drain();
    chk("ssat_sum", last_acc, 9'h100);
    chk("ssat_ovf", last_ovf, 1);

    // Backpressure: held result with a pending product for 10 cycles.
    len_cfg = 4'd1;
    send(8'd3, 1'b0);
    p_valid = 1'b1; p = 8'd9;
    repeat (10) tick();
    p_valid = 1'b0;
    drain();
    chk("bp_held", last_acc, 3);
    len_cfg = 4'd2;
    send(8'd4, 1'b0); send(8'd6, 1'b0);
    drain();
    chk("bp_next", last_acc, 10);

    // Abort after two terms; product presented with clear is dropped.
    len_cfg = 4'd4;
    send(8'd1, 1'b0); send(8'd2, 1'b0);
    p_valid = 1'b1; p = 8'd100; clear = 1'b1;
    tick();
    clear = 1'b0; p_valid = 1'b0;
    send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
    drain();
    chk("abort_sum", last_acc, 100);

    len_cfg = 4'd0;
    send(8'd7, 1'b0);
    drain();
    chk("len0_sum", last_acc, 7);
    len_cfg = 4'd4;
    send(8'd1, 1'b0);
    len_cfg = 4'd2;
    send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    drain();
    chk("len_latch_sum", last_acc, 10);

    // Clear while holding, then reset mid-frame.
    len_cfg = 4'd1;
    send(8'd5, 1'b0);
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    len_cfg = 4'd3;
    send(8'd1, 1'b0);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    drain();
    chk("post_reset_sum", last_acc, 9);

    for (int i = 0; i < 600; i++) begin
      p_valid   = ($urandom_range(0, 3) != 0);
      p         = 8'($urandom);
      Sign_out  = 1'($urandom);
      len_cfg   = 4'($urandom_range(0, 5));
      acc_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 150) == 0);
      tick();
    end
    p_valid = 1'b0; clear = 1'b0; rst = 1'b0; acc_ready = 1'b1;
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 128: operand width of the upstream Booth multiplier; the product is 2*WIDTH bits.
REQ-002 SHALL have parameter GUARD, default 8: accumulator guard bits; the accumulator is ACCW = 2*WIDTH+GUARD bits.
REQ-003 SHALL have parameter CNTW, default 8: width of the frame-length configuration and of the term counter.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge only.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 p  in  2*WIDTH  product from the upstream multiplier, qualified by p_valid.
REQ-007 Sign_out  in  1  1 = p is two's-complement, 0 = p is unsigned; sampled with each accepted p.
REQ-008 p_valid  in  1  upstream product valid.
REQ-009 p_ready  out  1  block can accept p this cycle.
REQ-010 len_cfg  in  CNTW  number of products per frame; 0 SHALL be treated as 1.
REQ-011 clear  in  1  synchronous frame abort.
REQ-012 acc_out  out  ACCW  accumulated frame result.
REQ-013 acc_valid  out  1  acc_out holds a completed frame.
REQ-014 acc_ready  in  1  downstream accepts acc_out.
REQ-015 ovf  out  1  sticky saturation flag for the frame in acc_out.

Function
REQ-016 A transfer SHALL occur on any cycle with p_valid=1 and p_ready=1; acc_out SHALL be consumed on any cycle with acc_valid=1 and acc_ready=1.
REQ-017 Two-state FSM: ACC (p_ready=1, acc_valid=0) and HOLD (p_ready=0, acc_valid=1).
REQ-018 ACC->HOLD SHALL occur on the transfer where the term count equals the frame length minus 1; acc_valid SHALL rise on the next edge (1-cycle latency from the last product).
REQ-019 HOLD->ACC SHALL occur on acc_ready=1. The accumulator, counter and ovf SHALL clear on that edge. The first new product SHALL NOT be accepted before the following cycle.
REQ-020 In HOLD, acc_out and ovf SHALL remain stable until consumed, regardless of p_valid.
REQ-021 len_cfg SHALL be latched on the first transfer of a frame; changes mid-frame SHALL have no effect until the next frame.
REQ-022 Each accepted p SHALL be extended to ACCW bits: sign-extended if Sign_out=1, zero-extended if Sign_out=0.
REQ-023 The first transfer of a frame SHALL load the extended p. Each later transfer SHALL add it to the accumulator.
REQ-024 On signed (Sign_out=1) overflow of the add, the accumulator SHALL saturate to the ACCW-bit signed max or min, and ovf SHALL set.
REQ-025 On unsigned carry-out, the accumulator SHALL saturate to all-ones, and ovf SHALL set.
REQ-026 ovf SHALL stay set until the frame is consumed or cleared.
REQ-027 clear=1 SHALL return the block to ACC with the accumulator, counter and ovf zeroed, discarding any frame in progress or held in HOLD. Any p presented in that cycle SHALL be dropped. clear SHALL have priority over every transfer.
REQ-028 len_cfg of 1 SHALL move the block to HOLD after a single transfer, with acc_out equal to the extended p.

Reset
REQ-029 While rst=1: FSM=ACC, accumulator=0, counter=0, latched length=1, ovf=0, acc_valid=0, p_ready=0.
REQ-030 p_ready SHALL assert on the first cycle after rst deasserts.
REQ-031 rst SHALL override clear and all handshakes. Reset mid-frame SHALL discard all partial state with no output produced.

Structure
REQ-032 A shared package SHALL hold the WIDTH, GUARD and CNTW defaults, the ACCW derivation and the FSM state encoding.
REQ-033 Saturating extend-and-add SHALL be one combinational sub-module, sat_acc_add, with inputs (acc, p, Sign_out) and outputs (sum, sat).
REQ-034 The FSM, counter and registers SHALL live in prod_accumulator.

Verification
REQ-035 Unsigned frame: len_cfg=3, Sign_out=0, p=5,7,9 on consecutive cycles -> acc_out=21, ovf=0, acc_valid one cycle after the third transfer.
REQ-036 Signed frame: len_cfg=2, Sign_out=1, p=-3 (all ones except LSBs), p=+1 -> acc_out=-2 sign-extended to ACCW, ovf=0.
REQ-037 Saturation, with WIDTH=4 and GUARD=1 (ACCW=9): unsigned p=255 repeated 3 times -> acc_out=511, ovf=1. Signed p=-128 repeated 3 times -> acc_out=-256, ovf=1.
REQ-038 Backpressure: hold acc_ready=0 for 10 cycles in HOLD while p_valid=1 -> p_ready=0 throughout, acc_out stable. Then acc_ready=1 -> new frame starts from 0.
REQ-039 Abort: clear pulse after 2 of 4 products -> no acc_valid. The next 4-product frame sums only the post-clear products.
REQ-040 len_cfg=0, and len_cfg changed mid-frame from 4 to 2 -> frame lengths of 1 and 4 respectively.
